// File: rtl/touch_debounce.sv
// Touch-sample debouncer: qualifies raw driver samples and emits one {x,y} press event per stable touch.
// Optional auto-repeat while held is compiled in with `define TOUCH_REPEAT_EN.
module touch_debounce #(
  parameter int CONFIRM_N   = 3,
  parameter int RELEASE_N   = 3,
  parameter int JITTER      = 8,
  parameter int TIMEOUT_CYC = 5_000_000,
  parameter int REPEAT_CYC  = 25_000_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        raw_valid,
  input  logic        raw_touch,
  input  logic [15:0] raw_x,
  input  logic [15:0] raw_y,
  output logic [31:0] touch_data,
  output logic        touch_pressed
);

  localparam int CNT_W  = $clog2(CONFIRM_N + 1);
  localparam int RCNT_W = $clog2(RELEASE_N + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, CONFIRM, PRESSED, RELEASE} state_t;

  state_t              state, state_nxt;
  logic [15:0]         ax, ay, ax_nxt, ay_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [RCNT_W-1:0]   rcnt, rcnt_nxt;
  logic [TMO_W-1:0]    tcnt, tcnt_nxt;
  logic signed [16:0]  dx, dy;
  logic                touch_ok, in_win, tmo_hit, emit, rpt_hit;
  logic [31:0]         evt_p1;

  function automatic logic [16:0] abs17(input logic signed [16:0] v);
    abs17 = v[16] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
    sat_cnt = (v >= CNT_W'(CONFIRM_N)) ? CNT_W'(CONFIRM_N) : v + 1'b1;
  endfunction

  function automatic logic [RCNT_W-1:0] sat_rcnt(input logic [RCNT_W-1:0] v);
    sat_rcnt = (v >= RCNT_W'(RELEASE_N)) ? RCNT_W'(RELEASE_N) : v + 1'b1;
  endfunction

  // Coordinate (0,0) is reserved as "no event", so it never qualifies as a touch.
  assign touch_ok = raw_valid && raw_touch && ({raw_x, raw_y} != 32'd0);
  assign dx       = $signed({1'b0, raw_x}) - $signed({1'b0, ax});
  assign dy       = $signed({1'b0, raw_y}) - $signed({1'b0, ay});
  assign in_win   = (abs17(dx) <= 17'(JITTER)) && (abs17(dy) <= 17'(JITTER));
  assign tmo_hit  = (state != IDLE) && !raw_valid && (tcnt == TMO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_nxt = state;
    ax_nxt    = ax;
    ay_nxt    = ay;
    cnt_nxt   = cnt;
    rcnt_nxt  = rcnt;
    emit      = 1'b0;
    if (tmo_hit) begin
      state_nxt = IDLE;
    end else if (raw_valid) begin
      unique case (state)
        IDLE: begin
          if (touch_ok) begin
            ax_nxt    = raw_x;
            ay_nxt    = raw_y;
            cnt_nxt   = CNT_W'(1);
            state_nxt = CONFIRM;
          end
        end
        CONFIRM: begin
          if (!touch_ok) begin
            state_nxt = IDLE;
          end else if (in_win) begin
            cnt_nxt = sat_cnt(cnt);
            if (cnt_nxt == CNT_W'(CONFIRM_N)) begin
              emit      = 1'b1;
              state_nxt = PRESSED;
            end
          end else begin
            ax_nxt  = raw_x;
            ay_nxt  = raw_y;
            cnt_nxt = CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!touch_ok) begin
            if (RELEASE_N <= 1) begin
              state_nxt = IDLE;
            end else begin
              rcnt_nxt  = RCNT_W'(1);
              state_nxt = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (touch_ok) begin
            state_nxt = PRESSED;
          end else begin
            rcnt_nxt = sat_rcnt(rcnt);
            if (rcnt_nxt == RCNT_W'(RELEASE_N)) state_nxt = IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    tcnt_nxt = tcnt + 1'b1;
    if (state == IDLE || raw_valid || tmo_hit) tcnt_nxt = '0;
  end

`ifdef TOUCH_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYC + 1);
  logic [RPT_W-1:0] rpt;

  assign rpt_hit = (state == PRESSED) && (rpt == RPT_W'(REPEAT_CYC - 1));

  // Counts only while held; frozen across a tentative release, cleared everywhere else.
  always_ff @(posedge clk) begin
    if (rstn) begin
      rpt <= '0;
    end else if (state == PRESSED) begin
      rpt <= rpt_hit ? '0 : rpt + 1'b1;
    end else if (state != RELEASE) begin
      rpt <= '0;
    end
  end
`else
  // Repeat compiled out: the term is constant false.
  assign rpt_hit = (REPEAT_CYC < 0);
`endif

  // Stage p1: registered state and one-cycle event
  always_ff @(posedge clk) begin
    if (rstn) begin
      state  <= IDLE;
      ax     <= '0;
      ay     <= '0;
      cnt    <= '0;
      rcnt   <= '0;
      tcnt   <= '0;
      evt_p1 <= '0;
    end else begin
      state  <= state_nxt;
      ax     <= ax_nxt;
      ay     <= ay_nxt;
      cnt    <= cnt_nxt;
      rcnt   <= rcnt_nxt;
      tcnt   <= tcnt_nxt;
      evt_p1 <= (emit || rpt_hit) ? {ax, ay} : 32'd0;
    end
  end

  assign touch_data    = evt_p1;
  assign touch_pressed = (state == PRESSED) || (state == RELEASE);

endmodule
